// File: rtl/control_cursor_ingreso.sv
// Edit-mode cursor FSM for the date/time entry datapath: field cursor, button edges,
// inc/dec strobes with auto-repeat steered to clock or timer registers, commit on exit.
module control_cursor_ingreso #(
  parameter int HOLD_DLY = 8,
  parameter int REP_PER  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic       C_T,
  input  logic       corre_der,
  input  logic       corre_izq,
  input  logic       aumenta,
  input  logic       disminuye,
  output logic [2:0] campo,
  output logic [5:0] sel_campo,
  output logic       inc_C,
  output logic       dec_C,
  output logic       inc_T,
  output logic       dec_T,
  output logic       editando,
  output logic       commit
);

  localparam int CNT_MAX = (HOLD_DLY > REP_PER) ? HOLD_DLY : REP_PER;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // State code doubles as the field index, so campo is the state itself while editing.
  localparam logic [2:0] S_SEG  = 3'd0;
  localparam logic [2:0] S_MIN  = 3'd1;
  localparam logic [2:0] S_HORA = 3'd2;
  localparam logic [2:0] S_DIA  = 3'd3;
  localparam logic [2:0] S_MES  = 3'd4;
  localparam logic [2:0] S_ANO  = 3'd5;
  localparam logic [2:0] IDLE   = 3'd6;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_INC  = 2'd1;
  localparam logic [1:0] R_DEC  = 2'd2;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_DLY);
  localparam logic [CW-1:0] REP_LD  = CW'(REP_PER);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          der_q, izq_q, aum_q, dis_q;

  logic [2:0] campo_q;
  logic [5:0] sel_q;
  logic       inc_c_q, dec_c_q, inc_t_q, dec_t_q, edit_q, commit_q;

  logic der_e, izq_e, aum_e, dis_e;
  logic up, dn, moved, to_clk, commit_d, edit_d;

  assign der_e = corre_der & ~der_q;
  assign izq_e = corre_izq & ~izq_q;
  assign aum_e = aumenta   & ~aum_q;
  assign dis_e = disminuye & ~dis_q;

  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    up       = 1'b0;
    dn       = 1'b0;
    moved    = 1'b0;
    if (!escribe) begin
      state_d  = IDLE;
      commit_d = (state_q <= S_ANO);
      rep_d    = R_NONE;
      cnt_d    = '0;
    end else if (state_q > S_ANO) begin
      state_d = S_SEG;
      rep_d   = R_NONE;
      cnt_d   = '0;
    end else begin
      if (der_e && !izq_e) begin
        state_d = (state_q == S_ANO) ? S_SEG : state_q + 3'd1;
        moved   = 1'b1;
      end else if (izq_e && !der_e) begin
        state_d = (state_q == S_SEG) ? S_ANO : state_q - 3'd1;
        moved   = 1'b1;
      end

      // A repeat only survives while its own button stays held alone; anything else
      // disarms it until a fresh press.
      if (moved || (aumenta && disminuye)) begin
        rep_d = R_NONE;
        cnt_d = '0;
      end else if (aum_e) begin
        up    = 1'b1;
        rep_d = R_INC;
        cnt_d = HOLD_LD;
      end else if (dis_e) begin
        dn    = 1'b1;
        rep_d = R_DEC;
        cnt_d = HOLD_LD;
      end else if ((rep_q == R_INC && aumenta) || (rep_q == R_DEC && disminuye)) begin
        if (cnt_q == CNT_ONE) begin
          up    = (rep_q == R_INC);
          dn    = (rep_q == R_DEC);
          cnt_d = REP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else begin
        rep_d = R_NONE;
        cnt_d = '0;
      end
    end
    to_clk = C_T || (state_q >= S_DIA);
    edit_d = (state_d <= S_ANO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rep_q    <= R_NONE;
      cnt_q    <= '0;
      der_q    <= 1'b0;
      izq_q    <= 1'b0;
      aum_q    <= 1'b0;
      dis_q    <= 1'b0;
      campo_q  <= 3'd0;
      sel_q    <= 6'd0;
      inc_c_q  <= 1'b0;
      dec_c_q  <= 1'b0;
      inc_t_q  <= 1'b0;
      dec_t_q  <= 1'b0;
      edit_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
      der_q    <= corre_der;
      izq_q    <= corre_izq;
      aum_q    <= aumenta;
      dis_q    <= disminuye;
      campo_q  <= edit_d ? state_d : 3'd0;
      sel_q    <= edit_d ? (6'b000001 << state_d) : 6'd0;
      inc_c_q  <= up &  to_clk;
      dec_c_q  <= dn &  to_clk;
      inc_t_q  <= up & ~to_clk;
      dec_t_q  <= dn & ~to_clk;
      edit_q   <= edit_d;
      commit_q <= commit_d;
    end
  end

  assign campo     = campo_q;
  assign sel_campo = sel_q;
  assign inc_C     = inc_c_q;
  assign dec_C     = dec_c_q;
  assign inc_T     = inc_t_q;
  assign dec_T     = dec_t_q;
  assign editando  = edit_q;
  assign commit    = commit_q;

endmodule
